opb_register_simulink2ppc_snap: RTL and testbench
=================================================

Name: opb_register_simulink2ppc_snap

Overview:
- OPB slave register carrying data from fabric user logic to the PowerPC. This is the opposite direction to the existing ppc2simulink software-control registers.
- User logic presents a 32-bit word with a valid strobe. The block captures it into a holding register and tracks new-data and overrun status.
- Software reads the data and status over OPB, and can freeze capture or clear status.
- All logic runs on OPB_Clk (single clock domain).

Parameters:
- C_BASEADDR, 32'h00000000, first byte address of the register window.
- C_HIGHADDR, 32'h000000FF, last byte address of the register window.
- C_OPB_AWIDTH, 32, OPB address width.
- C_OPB_DWIDTH, 32, OPB data width.
- C_FAMILY, "virtex5", target family; passed through, no functional effect.

Ports:
- OPB_Clk  in  1  sole clock
- OPB_Rst  in  1  synchronous, active-low reset
- Sl_DBus  out  [0:31]  read data; all zero except during a read ack
- Sl_errAck  out  1  tied 0
- Sl_retry  out  1  tied 0
- Sl_toutSup  out  1  tied 0
- Sl_xferAck  out  1  one-cycle transfer acknowledge
- OPB_ABus  in  [0:31]  address
- OPB_BE  in  [0:3]  byte enables; BE[3] covers DBus[24:31]
- OPB_DBus  in  [0:31]  write data
- OPB_RNW  in  1  1 = read
- OPB_select  in  1  transaction qualifier
- OPB_seqAddr  in  1  ignored
- user_data_in  in  [31:0]  word to capture
- user_valid  in  1  capture strobe
- user_frozen  out  1  mirror of CTRL.freeze

Behaviour:
- Bit mapping: Sl_DBus[i] = reg[31-i]; OPB_DBus[i] = reg bit 31-i.
- Register map, decoded by word offset OPB_ABus[28:29] inside the window:
  - 0x00 DATA (RO): holding register.
  - 0x04 STATUS (RO): [0] new, [1] frozen, [15:8] ovf_cnt, rest 0.
  - 0x08 CTRL (RW): [0] freeze; [1] clear (write-1 pulse, always reads 0).
  - 0x0C: reads 0; writes ignored but acked.
- Hit condition: OPB_select=1 and C_BASEADDR <= OPB_ABus <= C_HIGHADDR. Outside the window the block never acks and Sl_DBus stays 0.
- Slave FSM:
  - IDLE: on hit, go to ACK.
  - ACK (exactly 1 cycle): Sl_xferAck=1; Sl_DBus = addressed register if OPB_RNW=1, else 0. All side effects of the transfer happen in this cycle. Go to WAIT.
  - WAIT: hold until OPB_select=0, then go to IDLE. This prevents a second ack within one select assertion.
  - Latency: the ack comes 1 cycle after the first cycle select+hit is sampled.
- CTRL write: takes effect only when OPB_BE[3]=1. freeze <= DBus[31]; DBus[30]=1 asserts clear. Other byte lanes are ignored.
- Capture, evaluated every cycle:
  - Condition: user_valid=1 and freeze=0.
  - Action: DATA <= user_data_in and new <= 1.
  - If new was already 1, and is not being cleared this cycle by a DATA read or by clear, then ovf_cnt increments, saturating at 255.
- DATA read ack clears new, except when a capture occurs in the same cycle. In that case the capture wins: new=1 and there is no overrun increment.
- clear resets new=0 and ovf_cnt=0. A capture in the same cycle still sets new=1 and does not increment ovf_cnt.
- While freeze=1, user_valid is ignored completely: no capture, no overrun count.
- A freeze write is effective from the cycle after ACK. A capture in the ACK cycle itself still occurs.
- Reset (OPB_Rst=0 at a clock edge):
  - FSM goes to IDLE; DATA=0, new=0, ovf_cnt=0, freeze=0.
  - Sl_xferAck=0, Sl_DBus=0, user_frozen=0.
  - A transaction in flight is dropped without an ack.

Test Plan:
- Reset, then read 0x00 and 0x04 -> xferAck one cycle after select; data 0x00000000 and 0x00000000; Sl_DBus=0 on every non-ack cycle.
- user_valid with 0xDEADBEEF, then read STATUS -> 0x00000001. Read DATA -> 0xDEADBEEF. Read STATUS again -> 0x00000000.
- Three valids (0x1, 0x2, 0x3) with no read -> DATA=0x3, STATUS=0x00000201. Then 300 more valids -> ovf_cnt saturates, STATUS=0x0000FF01.
- Write CTRL=0x1 with BE=1111, then user_valid 0xAAAA5555 -> DATA unchanged; STATUS bit1=1; user_frozen=1. Write CTRL=0x1 with BE=1110 -> ignored.
- DATA read ack coincident with user_valid 0x12345678 -> read returns the old value; afterwards new=1 and ovf_cnt unchanged. Write CTRL=0x2 -> new=0, ovf_cnt=0; CTRL reads back with bit1=0.
- Select held for 5 cycles -> exactly one xferAck. Address C_HIGHADDR+4 -> no ack. OPB_Rst=0 asserted on the cycle between select and ack -> no ack issued; all registers read 0 afterwards.

Source files
------------

// File: rtl/opb_register_simulink2ppc_snap.sv
// OPB slave register: captures a word from fabric user logic and exposes it,
// with new-data / overrun status and freeze / clear control, to the PowerPC.
module opb_register_simulink2ppc_snap #(
    parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
    parameter logic [31:0] C_HIGHADDR   = 32'h0000_00FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter              C_FAMILY     = "virtex5"
) (
    input  logic                    OPB_Clk,
    input  logic                    OPB_Rst,
    output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
    output logic                    Sl_errAck,
    output logic                    Sl_retry,
    output logic                    Sl_toutSup,
    output logic                    Sl_xferAck,
    input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
    input  logic [0:3]              OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
    input  logic                    OPB_RNW,
    input  logic                    OPB_select,
    input  logic                    OPB_seqAddr,
    input  logic [31:0]             user_data_in,
    input  logic                    user_valid,
    output logic                    user_frozen
);

    typedef enum logic [1:0] {S_IDLE, S_ACK, S_WAIT} state_t;

    localparam logic [31:0] ADDR_SPAN = C_HIGHADDR - C_BASEADDR;

    state_t      state_q, state_d;
    logic [31:0] data_q, data_d;
    logic        new_q, new_d;
    logic [7:0]  ovf_q, ovf_d;
    logic        freeze_q, freeze_d;

    logic [31:0] addr;
    logic [31:0] wr_word;
    logic [1:0]  word_off;
    logic        hit;
    logic        xfer_ack;
    logic        rd_data_ack;
    logic        ctrl_wr;
    logic        clear;
    logic        capture;
    logic [31:0] rd_word;
    logic        unused_inputs;

    // Big-endian OPB bus: bit 0 is the MSB, so a plain assignment maps
    // OPB bit i onto register bit 31-i.
    assign addr     = OPB_ABus;
    assign wr_word  = OPB_DBus;
    assign word_off = addr[3:2];

    // Offset compare handles the window in one unsigned test, even at base 0.
    assign hit = OPB_select && ((addr - C_BASEADDR) <= ADDR_SPAN);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned and a latch is never inferred.
        state_d  = state_q;
        xfer_ack = 1'b0;
        case (state_q)
            S_IDLE: if (hit) state_d = S_ACK;
            S_ACK: begin
                xfer_ack = 1'b1;
                state_d  = S_WAIT;
            end
            S_WAIT:  if (!OPB_select) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign rd_data_ack = xfer_ack && OPB_RNW && (word_off == 2'd0);
    assign ctrl_wr     = xfer_ack && !OPB_RNW && (word_off == 2'd2) && OPB_BE[3];
    assign clear       = ctrl_wr && wr_word[1];
    assign capture     = user_valid && !freeze_q;

    always_comb begin
        data_d   = data_q;
        new_d    = new_q;
        ovf_d    = ovf_q;
        freeze_d = freeze_q;
        if (capture) begin
            data_d = user_data_in;
            new_d  = 1'b1;
            // A capture only overruns data nobody is consuming this cycle.
            if (new_q && !rd_data_ack && !clear && (ovf_q != 8'hFF))
                ovf_d = ovf_q + 8'd1;
        end else if (rd_data_ack || clear) begin
            new_d = 1'b0;
        end
        if (clear)   ovf_d    = 8'd0;
        if (ctrl_wr) freeze_d = wr_word[0];
    end

    always_comb begin
        rd_word = 32'h0;
        case (word_off)
            2'd0:    rd_word = data_q;
            2'd1:    rd_word = {16'h0, ovf_q, 6'h0, freeze_q, new_q};
            2'd2:    rd_word = {31'h0, freeze_q};
            default: rd_word = 32'h0;
        endcase
    end

    always_ff @(posedge OPB_Clk) begin
        // NOTE: sequential state uses non-blocking assignments only; the reset
        // is synchronous, so it is just the highest-priority branch here.
        if (!OPB_Rst) begin
            state_q  <= S_IDLE;
            data_q   <= 32'h0;
            new_q    <= 1'b0;
            ovf_q    <= 8'd0;
            freeze_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            new_q    <= new_d;
            ovf_q    <= ovf_d;
            freeze_q <= freeze_d;
        end
    end

    assign Sl_DBus     = (xfer_ack && OPB_RNW) ? rd_word : '0;
    assign Sl_xferAck  = xfer_ack;
    assign Sl_errAck   = 1'b0;
    assign Sl_retry    = 1'b0;
    assign Sl_toutSup  = 1'b0;
    assign user_frozen = freeze_q;

    assign unused_inputs = ^{OPB_seqAddr, OPB_BE[0:2], wr_word[31:2], (C_FAMILY == "virtex5")};

endmodule

// File: tb/tb_opb_register_simulink2ppc_snap.sv
// Self-checking bench: directed vector table, hand-written corner sequences,
// then randomized OPB traffic and user captures against a behavioural model.
module tb_opb_register_simulink2ppc_snap;

    localparam logic [31:0] HIGH = 32'h0000_00FF;  // window base is 0

    logic        clk = 1'b0;
    logic        rst_n;
    logic [0:31] sl_dbus;
    logic        sl_erracK, sl_retry, sl_toutsup, sl_xferack;
    logic [0:31] opb_abus, opb_dbus;
    logic [0:3]  opb_be;
    logic        opb_rnw, opb_select, opb_seqaddr;
    logic [31:0] user_data_in;
    logic        user_valid, user_frozen;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    // Behavioural model of the software-visible state.
    logic [31:0] m_data;
    logic        m_new, m_freeze;
    logic [7:0]  m_ovf;

    opb_register_simulink2ppc_snap dut (
        .OPB_Clk     (clk),
        .OPB_Rst     (rst_n),
        .Sl_DBus     (sl_dbus),
        .Sl_errAck   (sl_erracK),
        .Sl_retry    (sl_retry),
        .Sl_toutSup  (sl_toutsup),
        .Sl_xferAck  (sl_xferack),
        .OPB_ABus    (opb_abus),
        .OPB_BE      (opb_be),
        .OPB_DBus    (opb_dbus),
        .OPB_RNW     (opb_rnw),
        .OPB_select  (opb_select),
        .OPB_seqAddr (opb_seqaddr),
        .user_data_in(user_data_in),
        .user_valid  (user_valid),
        .user_frozen (user_frozen)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Read data must be zero on every cycle that is not an acknowledge.
    always @(negedge clk)
        if (mon_en && !sl_xferack) check("dbus_idle_zero", sl_dbus, 32'h0);

    function automatic void m_reset();
        m_data = 32'h0; m_new = 1'b0; m_ovf = 8'd0; m_freeze = 1'b0;
    endfunction

    // One clock edge of software-visible behaviour.
    function automatic void m_cycle(input logic valid, input logic [31:0] vdata,
                                    input logic data_read, input logic clr,
                                    input logic ctrl_wr, input logic fval);
        bit took, consumed, overrun;
        took     = valid && !m_freeze;
        consumed = data_read || clr;
        overrun  = took && m_new && !consumed;
        if (clr) m_ovf = 8'd0;
        else if (overrun && m_ovf < 8'd255) m_ovf = m_ovf + 8'd1;
        m_new = took || (m_new && !consumed);
        if (took) m_data = vdata;
        if (ctrl_wr) m_freeze = fval;
    endfunction

    function automatic logic [31:0] m_read(input logic [1:0] off);
        case (off)
            2'd0:    return m_data;
            2'd1:    return {16'h0, m_ovf, 6'h0, m_freeze, m_new};
            2'd2:    return {31'h0, m_freeze};
            default: return 32'h0;
        endcase
    endfunction

    task automatic valid_cycle(input logic v, input logic [31:0] d);
        @(negedge clk);
        user_valid = v; user_data_in = d;
        @(posedge clk);
        m_cycle(v, d, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 user_valid = 1'b0;
    endtask

    // One OPB transfer; be is written as BE[0..3] left to right.
    task automatic xfer(input logic [31:0] addr, input logic rnw, input logic [31:0] wdata,
                        input logic [3:0] be, input logic cap, input logic [31:0] cdata,
                        output logic acked, output logic [31:0] rdata);
        logic hit, is_ctrl;
        hit     = (addr <= HIGH);
        is_ctrl = hit && !rnw && (addr[3:2] == 2'd2) && be[0];
        acked = 1'b0; rdata = 32'h0;
        @(negedge clk);
        opb_abus = addr; opb_rnw = rnw; opb_dbus = rnw ? 32'h0 : wdata;
        opb_be = be; opb_select = 1'b1;
        @(posedge clk);
        #1 check("ack_latency", sl_xferack, hit);
        if (sl_xferack) begin
            acked = 1'b1;
            rdata = sl_dbus;
            user_valid = cap; user_data_in = cdata;
            @(posedge clk);
            m_cycle(cap, cdata, hit && rnw && (addr[3:2] == 2'd0),
                    is_ctrl && wdata[1], is_ctrl, wdata[0]);
            #1 check("single_ack", sl_xferack, 1'b0);
        end else begin
            for (int k = 0; k < 3; k++) begin
                @(posedge clk);
                #1 check("no_late_ack", sl_xferack, 1'b0);
            end
        end
        user_valid = 1'b0; opb_select = 1'b0; opb_abus = '0; opb_rnw = 1'b0;
        opb_dbus = '0; opb_be = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
        logic a; logic [31:0] d;
        xfer(addr, 1'b1, 32'h0, 4'hF, 1'b0, 32'h0, a, d);
        check({name, "_ack"}, a, 1'b1);
        check(name, d, exp);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be,
                      input logic cap, input logic [31:0] cdata);
        logic a; logic [31:0] d;
        xfer(addr, 1'b0, data, be, cap, cdata, a, d);
        check("wr_ack", a, 1'b1);
        check("wr_dbus_zero", d, 32'h0);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        rnw;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        pre_valid;
        logic [31:0] pre_data;
        logic        cap;
        logic [31:0] cdata;
        logic        exp_ack;
        logic [31:0] exp_rdata;
        logic        exp_frozen;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] addr, input logic rnw, input logic [31:0] wdata,
                                input logic [3:0] be, input logic pv, input logic [31:0] pd,
                                input logic cap, input logic [31:0] cd, input logic ea,
                                input logic [31:0] er, input logic ef);
        vec_t v;
        v.addr = addr; v.rnw = rnw; v.wdata = wdata; v.be = be;
        v.pre_valid = pv; v.pre_data = pd; v.cap = cap; v.cdata = cd;
        v.exp_ack = ea; v.exp_rdata = er; v.exp_frozen = ef;
        return v;
    endfunction

    initial begin
        vec_t        vecs[$];
        logic        a, rnw, cap, exp_ack;
        logic [31:0] d, addr, wdata, cd, exp_rd;
        logic [3:0]  be;
        int          acks;

        //           addr     rnw wdata          be     pv pre_data       cap cdata          ack rdata          frz
        vecs.push_back(mk(32'h00, 1, 32'h0,          4'hF, 0, 32'h0,          0, 32'h0,          1, 32'h0,          0));
        vecs.push_back(mk(32'h04, 1, 32'h0,          4'hF, 0, 32'h0,          0, 32'h0,          1, 32'h0,          0));
        vecs.push_back(mk(32'h04, 1, 32'h0,          4'hF, 1, 32'hDEADBEEF,   0, 32'h0,          1, 32'h1,          0));
        vecs.push_back(mk(32'h00, 1, 32'h0,          4'hF, 0, 32'h0,          0, 32'h0,          1, 32'hDEADBEEF,   0));
        vecs.push_back(mk(32'h04, 1, 32'h0,          4'hF, 0, 32'h0,          0, 32'h0,          1, 32'h0,          0));
        vecs.push_back(mk(32'h08, 1, 32'h0,          4'hF, 0, 32'h0,          0, 32'h0,          1, 32'h0,          0));
        vecs.push_back(mk(32'h0C, 1, 32'h0,          4'hF, 0, 32'h0,          0, 32'h0,          1, 32'h0,          0));
        vecs.push_back(mk(32'h0C, 0, 32'hFFFFFFFF,   4'hF, 0, 32'h0,          0, 32'h0,          1, 32'h0,          0));
        vecs.push_back(mk(32'h04, 1, 32'h0,          4'hF, 0, 32'h0,          0, 32'h0,          1, 32'h0,          0));
        vecs.push_back(mk(32'h08, 0, 32'h1,          4'hF, 0, 32'h0,          0, 32'h0,          1, 32'h0,          1));
        vecs.push_back(mk(32'h00, 1, 32'h0,          4'hF, 1, 32'hAAAA5555,   0, 32'h0,          1, 32'hDEADBEEF,   1));
        vecs.push_back(mk(32'h04, 1, 32'h0,          4'hF, 0, 32'h0,          0, 32'h0,          1, 32'h2,          1));
        vecs.push_back(mk(32'h08, 0, 32'h0,          4'hE, 0, 32'h0,          0, 32'h0,          1, 32'h0,          1));
        vecs.push_back(mk(32'h08, 1, 32'h0,          4'hF, 0, 32'h0,          0, 32'h0,          1, 32'h1,          1));
        vecs.push_back(mk(32'h08, 0, 32'h0,          4'h1, 0, 32'h0,          0, 32'h0,          1, 32'h0,          0));
        vecs.push_back(mk(32'h08, 1, 32'h0,          4'hF, 0, 32'h0,          0, 32'h0,          1, 32'h0,          0));
        vecs.push_back(mk(32'h00, 1, 32'h0,          4'hF, 1, 32'h11111111,   1, 32'h12345678,   1, 32'h11111111,   0));
        vecs.push_back(mk(32'h04, 1, 32'h0,          4'hF, 0, 32'h0,          0, 32'h0,          1, 32'h1,          0));
        vecs.push_back(mk(32'h00, 1, 32'h0,          4'hF, 0, 32'h0,          0, 32'h0,          1, 32'h12345678,   0));
        vecs.push_back(mk(32'hFC, 1, 32'h0,          4'hF, 0, 32'h0,          0, 32'h0,          1, 32'h0,          0));
        vecs.push_back(mk(32'hFF, 1, 32'h0,          4'hF, 0, 32'h0,          0, 32'h0,          1, 32'h0,          0));
        vecs.push_back(mk(32'h103,1, 32'h0,          4'hF, 0, 32'h0,          0, 32'h0,          0, 32'h0,          0));
        vecs.push_back(mk(32'h108,0, 32'h1,          4'hF, 0, 32'h0,          0, 32'h0,          0, 32'h0,          0));
        vecs.push_back(mk(32'h08, 0, 32'h3,          4'hF, 0, 32'h0,          0, 32'h0,          1, 32'h0,          1));
        vecs.push_back(mk(32'h04, 1, 32'h0,          4'hF, 0, 32'h0,          0, 32'h0,          1, 32'h2,          1));
        vecs.push_back(mk(32'h08, 0, 32'h0,          4'hF, 0, 32'h0,          0, 32'h0,          1, 32'h0,          0));

        rst_n = 1'b0; opb_abus = '0; opb_dbus = '0; opb_be = '0; opb_rnw = 1'b0;
        opb_select = 1'b0; opb_seqaddr = 1'b0; user_data_in = 32'h0; user_valid = 1'b0;
        m_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_xferack", sl_xferack, 1'b0);
        check("rst_dbus", sl_dbus, 32'h0);
        check("rst_frozen", user_frozen, 1'b0);
        check("tied_zero", {sl_erracK, sl_retry, sl_toutsup}, 3'b000);
        mon_en = 1'b1;

        foreach (vecs[i]) begin
            if (vecs[i].pre_valid) valid_cycle(1'b1, vecs[i].pre_data);
            xfer(vecs[i].addr, vecs[i].rnw, vecs[i].wdata, vecs[i].be,
                 vecs[i].cap, vecs[i].cdata, a, d);
            check($sformatf("vec%0d_ack", i), a, vecs[i].exp_ack);
            check($sformatf("vec%0d_rdata", i), d, vecs[i].exp_rdata);
            check($sformatf("vec%0d_frozen", i), user_frozen, vecs[i].exp_frozen);
        end

        // Overrun counting and saturation.
        valid_cycle(1'b1, 32'h1);
        valid_cycle(1'b1, 32'h2);
        valid_cycle(1'b1, 32'h3);
        rd_chk("ovf_status2", 32'h04, 32'h0000_0201);
        rd_chk("ovf_data3", 32'h00, 32'h3);
        for (int k = 0; k < 300; k++) valid_cycle(1'b1, 32'(k));
        rd_chk("ovf_saturate", 32'h04, 32'h0000_FF01);

        // Clear coinciding with a capture: capture sets new, counter zeroed.
        wr(32'h08, 32'h2, 4'hF, 1'b1, 32'h55);
        rd_chk("clr_cap_status", 32'h04, 32'h1);
        rd_chk("clr_cap_data", 32'h00, 32'h55);
        valid_cycle(1'b1, 32'h66);
        valid_cycle(1'b1, 32'h77);
        rd_chk("pre_clr_status", 32'h04, 32'h0000_0101);
        wr(32'h08, 32'h2, 4'hF, 1'b0, 32'h0);
        rd_chk("clr_status", 32'h04, 32'h0);
        rd_chk("clr_ctrl_reads0", 32'h08, 32'h0);

        // Select held for five cycles yields exactly one acknowledge.
        @(negedge clk);
        opb_abus = 32'h04; opb_rnw = 1'b1; opb_be = 4'hF; opb_select = 1'b1;
        acks = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1 if (sl_xferack) acks++;
        end
        @(negedge clk);
        opb_select = 1'b0;
        @(posedge clk);
        #1 check("hold_one_ack", acks, 1);

        // Reset landing between select and acknowledge drops the transfer.
        valid_cycle(1'b1, 32'hCAFEF00D);
        wr(32'h08, 32'h1, 4'hF, 1'b0, 32'h0);
        check("pre_rst_frozen", user_frozen, 1'b1);
        @(negedge clk);
        opb_abus = 32'h00; opb_rnw = 1'b1; opb_select = 1'b1; rst_n = 1'b0;
        @(posedge clk);
        #1 check("rst_inflight_no_ack", sl_xferack, 1'b0);
        @(negedge clk);
        opb_select = 1'b0;
        @(posedge clk);
        #1 check("rst_hold_no_ack", sl_xferack, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        check("post_rst_frozen", user_frozen, 1'b0);
        rd_chk("post_rst_data", 32'h00, 32'h0);
        rd_chk("post_rst_status", 32'h04, 32'h0);
        rd_chk("post_rst_ctrl", 32'h08, 32'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                for (int k = 0; k < int'($urandom_range(1, 4)); k++)
                    valid_cycle(1'($urandom_range(0, 1)), $urandom);
            end else begin
                addr  = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(256, 511))
                                                    : 32'($urandom_range(0, 255));
                rnw   = 1'($urandom_range(0, 1));
                wdata = ($urandom & 32'hFFFF_FFFC) |
                        {30'h0, 1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 3) == 0)};
                be    = 4'($urandom_range(0, 15));
                cap   = 1'($urandom_range(0, 1));
                cd    = $urandom;
                exp_ack = (addr <= HIGH);
                exp_rd  = (exp_ack && rnw) ? m_read(addr[3:2]) : 32'h0;
                xfer(addr, rnw, wdata, be, cap, cd, a, d);
                check("rand_ack", a, exp_ack);
                check("rand_rdata", d, exp_rd);
                check("rand_frozen", user_frozen, m_freeze);
            end
        end
        rd_chk("rand_final_status", 32'h04, m_read(2'd1));
        rd_chk("rand_final_data", 32'h00, m_read(2'd0));

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
